// File: rtl/song_player_pkg.sv
// Shared definitions for the song player: song-table word layout, pitch codes
// and the sequencer state encoding.
package song_player_pkg;

  localparam int NOTE_MSB  = 15;
  localparam int NOTE_LSB  = 9;
  localparam int PITCH_MSB = 8;
  localparam int PITCH_LSB = 6;
  localparam int DUR_MSB   = 5;
  localparam int DUR_LSB   = 0;

  localparam logic [2:0] PITCH_LOW  = 3'b001;
  localparam logic [2:0] PITCH_MID  = 3'b010;
  localparam logic [2:0] PITCH_HIGH = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_e;

  function automatic logic is_pitch_code(input logic [2:0] p);
    return (p == PITCH_LOW) || (p == PITCH_MID) || (p == PITCH_HIGH);
  endfunction

endpackage

// File: rtl/song_player_tick_gen.sv
// Timing-tick divider: counts 0..TICK_DIV-1 while enabled and strobes tick_o
// for one cycle at the terminal count. Synchronous clear wins over enable.
module song_player_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/song_player.sv
// Auto-play sequencer: walks the song table and drives the buzzer note/pitch
// vectors for each entry's duration, with a silent gap between entries.
module song_player
  import song_player_pkg::*;
#(
  parameter int TICK_DIV   = 1_000_000,
  parameter int UNIT_TICKS = 12,
  parameter int GAP_TICKS  = 2,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [6:0]        note,
  output logic [2:0]        pitch,
  output logic              playing,
  output logic              done,
  output state_e            dbg_state
);

  localparam logic [15:0] UNIT16 = 16'(UNIT_TICKS);
  localparam logic [15:0] GAP16  = 16'(GAP_TICKS);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [6:0]        cur_note_q;
  logic [6:0]        note_q;
  logic [2:0]        pitch_q;
  logic              playing_q;
  logic              done_q;
  logic [15:0]       dur_cnt_q;
  logic [15:0]       gap_cnt_q;

  logic        tick;
  logic        div_en;
  logic        div_clr;
  logic [6:0]  rom_note;
  logic [2:0]  rom_pitch;
  logic [5:0]  rom_dur;
  logic [15:0] load_ticks;

  assign rom_note   = rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_pitch  = rom_data[PITCH_MSB:PITCH_LSB];
  assign rom_dur    = rom_data[DUR_MSB:DUR_LSB];
  assign load_ticks = 16'(rom_dur) * UNIT16;

  // Clearing in LOAD phase-aligns the divider so every entry lasts exactly
  // dur*UNIT_TICKS*TICK_DIV cycles regardless of FETCH/LOAD overhead.
  assign div_en  = (state_q != S_IDLE) && !pause;
  assign div_clr = (state_q == S_LOAD) || ((state_q == S_IDLE) && start && !stop);

  song_player_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (div_en),
    .clr_i (div_clr),
    .tick_o(tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cur_note_q <= '0;
      note_q     <= '0;
      pitch_q    <= PITCH_MID;
      playing_q  <= 1'b0;
      done_q     <= 1'b0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else if (stop) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      note_q    <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_FETCH;
            addr_q    <= '0;
            playing_q <= 1'b1;
            dur_cnt_q <= '0;
            gap_cnt_q <= '0;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          if (rom_dur == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            note_q  <= '0;
          end else begin
            cur_note_q <= rom_note;
            pitch_q    <= is_pitch_code(rom_pitch) ? rom_pitch : PITCH_MID;
            note_q     <= pause ? '0 : rom_note;
            dur_cnt_q  <= load_ticks;
            state_q    <= S_PLAY;
          end
        end
        S_PLAY: begin
          note_q <= pause ? '0 : cur_note_q;
          if (tick) begin
            if (dur_cnt_q == 16'd1) begin
              dur_cnt_q <= '0;
              note_q    <= '0;
              gap_cnt_q <= GAP16;
              state_q   <= S_GAP;
            end else begin
              dur_cnt_q <= dur_cnt_q - 16'd1;
            end
          end
        end
        S_GAP: begin
          note_q <= '0;
          if (tick) begin
            if (gap_cnt_q == 16'd1) begin
              gap_cnt_q <= '0;
              if (&addr_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                addr_q  <= addr_q + ADDR_W'(1);
                state_q <= S_FETCH;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q - 16'd1;
            end
          end
        end
        S_DONE: begin
          note_q    <= '0;
          playing_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr  = addr_q;
  assign note      = note_q;
  assign pitch     = pitch_q;
  assign playing   = playing_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
